// File: rtl/conv_stream_feeder.sv
// Buffers one image frame and one KxK weight set, then streams iNumFrames frames to the conv core.
// Optional CONV_FEED_WT_RELOAD_EN: resend weight beats at the start of every frame (default: frame 0 only).
module conv_stream_feeder #(
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int K          = 5,
  parameter int DW         = 8,
  parameter int FRAME_BITS = 4
) (
  input  logic                           iCLK,
  input  logic                           iRST,
  input  logic                           iPixWe,
  input  logic [$clog2(IMG_W*IMG_H)-1:0] iPixAddr,
  input  logic [DW-1:0]                  iPixData,
  input  logic                           iWtWe,
  input  logic [$clog2(K*K)-1:0]         iWtAddr,
  input  logic [DW-1:0]                  iWtData,
  input  logic                           iStart,
  input  logic                           iAbort,
  input  logic [FRAME_BITS-1:0]          iNumFrames,
  output logic                           oValid,
  output logic                           oWren,
  output logic [$clog2(K*K)-1:0]         oADDR,
  output logic [DW-1:0]                  oX,
  output logic [DW-1:0]                  oW,
  output logic                           oBusy,
  output logic                           oDone,
  output logic [FRAME_BITS-1:0]          oFrameCnt
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int NTAP = K * K;
  localparam int PAW  = $clog2(NPIX);
  localparam int TAW  = $clog2(NTAP);
`ifdef CONV_FEED_WT_RELOAD_EN
  localparam bit WT_RELOAD = 1'b1;
`else
  localparam bit WT_RELOAD = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM, S_FINISH} state_t;

  logic [DW-1:0] pix_mem [NPIX];
  logic [DW-1:0] wt_mem  [NTAP];

  state_t                state_q, state_d;
  logic [PAW-1:0]        pix_q, pix_d;
  logic [FRAME_BITS-1:0] frm_q, frm_d;
  logic [FRAME_BITS-1:0] nfrm_q, nfrm_d;
  logic                  valid_q, valid_d;
  logic                  wren_q, wren_d;
  logic [TAW-1:0]        addr_q, addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [FRAME_BITS-1:0] frmcnt_q, frmcnt_d;
  logic [DW-1:0]         x_q, w_q;
  logic                  issue, wt_sel;

  // A beat is "issued" the cycle before it is presented: the buffer read and
  // the output registers load on the same edge.
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    frm_d   = frm_q;
    nfrm_d  = nfrm_q;
    issue   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (iStart && !iAbort) begin
          if (iNumFrames != '0) begin
            state_d = S_PRIME;
            nfrm_d  = iNumFrames;
            pix_d   = '0;
            frm_d   = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_PRIME, S_STREAM: begin
        issue   = 1'b1;
        state_d = S_STREAM;
        if (pix_q == PAW'(NPIX - 1)) begin
          pix_d = '0;
          if (frm_q == nfrm_q - 1'b1) state_d = S_FINISH;
          else                        frm_d   = frm_q + 1'b1;
        end else begin
          pix_d = pix_q + 1'b1;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (iAbort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      issue   = 1'b0;
      done_d  = 1'b0;
    end
    wt_sel   = issue && (int'(pix_q) < NTAP) && (frm_q == '0 || WT_RELOAD);
    valid_d  = issue;
    wren_d   = wt_sel;
    addr_d   = wt_sel ? pix_q[TAW-1:0] : '0;
    frmcnt_d = issue ? frm_q : '0;
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= S_IDLE;
      pix_q    <= '0;
      frm_q    <= '0;
      nfrm_q   <= '0;
      valid_q  <= 1'b0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      frmcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      pix_q    <= pix_d;
      frm_q    <= frm_d;
      nfrm_q   <= nfrm_d;
      valid_q  <= valid_d;
      wren_q   <= wren_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      frmcnt_q <= frmcnt_d;
    end
  end

  // Host loads are only accepted while idle so a running stream never sees torn data.
  always_ff @(posedge iCLK) begin
    if (iPixWe && state_q == S_IDLE && int'(iPixAddr) < NPIX) pix_mem[iPixAddr] <= iPixData;
    if (iWtWe && state_q == S_IDLE && int'(iWtAddr) < NTAP)   wt_mem[iWtAddr]   <= iWtData;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      x_q <= '0;
      w_q <= '0;
    end else begin
      x_q <= issue  ? pix_mem[pix_q]          : '0;
      w_q <= wt_sel ? wt_mem[pix_q[TAW-1:0]]  : '0;
    end
  end

  assign oValid    = valid_q;
  assign oWren     = wren_q;
  assign oADDR     = addr_q;
  assign oX        = x_q;
  assign oW        = w_q;
  assign oBusy     = busy_q;
  assign oDone     = done_q;
  assign oFrameCnt = frmcnt_q;

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Directed bench for conv_stream_feeder: reset, single/multi frame streams, zero frames, abort, busy protection.
module tb_conv_stream_feeder;
  localparam int NPIX = 1024;
  localparam int NTAP = 25;
`ifdef CONV_FEED_WT_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       iPixWe = 1'b0;
  logic [9:0] iPixAddr = '0;
  logic [7:0] iPixData = '0;
  logic       iWtWe = 1'b0;
  logic [4:0] iWtAddr = '0;
  logic [7:0] iWtData = '0;
  logic       iStart = 1'b0;
  logic       iAbort = 1'b0;
  logic [3:0] iNumFrames = '0;
  logic       oValid, oWren, oBusy, oDone;
  logic [4:0] oADDR;
  logic [7:0] oX, oW;
  logic [3:0] oFrameCnt;

  int checks = 0;
  int errors = 0;

  conv_stream_feeder dut (
    .iCLK(iCLK), .iRST(iRST),
    .iPixWe(iPixWe), .iPixAddr(iPixAddr), .iPixData(iPixData),
    .iWtWe(iWtWe), .iWtAddr(iWtAddr), .iWtData(iWtData),
    .iStart(iStart), .iAbort(iAbort), .iNumFrames(iNumFrames),
    .oValid(oValid), .oWren(oWren), .oADDR(oADDR), .oX(oX), .oW(oW),
    .oBusy(oBusy), .oDone(oDone), .oFrameCnt(oFrameCnt)
  );

  always #5 iCLK = ~iCLK;

  // {valid, wren, addr, x, w, frame, busy, done}
  localparam logic [28:0] ZERO_V = 29'd0;
  localparam logic [28:0] BUSY_V = 29'd2;
  localparam logic [28:0] DONE_V = 29'd1;

  function automatic logic [28:0] obs();
    return {oValid, oWren, oADDR, oX, oW, oFrameCnt, oBusy, oDone};
  endfunction

  function automatic logic [28:0] beat_v(input int j, input int f);
    logic       wr;
    logic [4:0] a;
    logic [7:0] x, w;
    wr = (j < NTAP) && (f == 0 || RELOAD);
    a  = wr ? 5'(j) : 5'd0;
    x  = 8'(j % 128);
    w  = wr ? 8'(j - 12) : 8'd0;
    return {1'b1, wr, a, x, w, 4'(f), 1'b1, 1'b0};
  endfunction

  task automatic cyc();
    @(negedge iCLK);
  endtask

  task automatic chk(input string tag, input int idx, input logic [28:0] o, input logic [28:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, o, e);
    end
  endtask

  // Called at the cycle presenting beat 0 of frame 0; checks every beat then the done pulse.
  task automatic check_run(input string tag, input int nfr);
    for (int f = 0; f < nfr; f++)
      for (int j = 0; j < NPIX; j++) begin
        chk(tag, f * NPIX + j, obs(), beat_v(j, f));
        cyc();
      end
    chk({tag, "_done"}, 0, obs(), DONE_V);
    cyc();
    chk({tag, "_idle"}, 0, obs(), ZERO_V);
  endtask

  initial begin
    // Reset
    cyc(); cyc(); cyc();
    chk("reset_hold", 0, obs(), ZERO_V);
    iRST = 1'b0;
    cyc();
    chk("reset_rel", 0, obs(), ZERO_V);

    // Buffer loads (plus one out-of-range weight write that must be ignored)
    for (int j = 0; j < NPIX; j++) begin
      iPixWe = 1'b1; iPixAddr = 10'(j); iPixData = 8'(j % 128);
      cyc();
    end
    iPixWe = 1'b0;
    for (int k = 0; k < NTAP + 1; k++) begin
      iWtWe = 1'b1; iWtAddr = 5'(k); iWtData = (k < NTAP) ? 8'(k - 12) : 8'h55;
      cyc();
    end
    iWtWe = 1'b0;
    cyc();
    chk("load_idle", 0, obs(), ZERO_V);

    // Single frame, with a pixel write and a start attempted mid-stream
    iNumFrames = 4'd1; iStart = 1'b1;
    cyc();
    iStart = 1'b0;
    chk("single_prime", 0, obs(), BUSY_V);
    cyc();
    for (int j = 0; j < NPIX; j++) begin
      chk("single_beat", j, obs(), beat_v(j, 0));
      if (j == 100) begin
        iPixWe = 1'b1; iPixAddr = 10'd5; iPixData = 8'd99; iStart = 1'b1; iNumFrames = 4'd7;
      end else begin
        iPixWe = 1'b0; iStart = 1'b0;
      end
      cyc();
    end
    chk("single_done", 0, obs(), DONE_V);
    cyc();
    chk("single_idle", 0, obs(), ZERO_V);
    cyc();
    chk("single_norestart", 0, obs(), ZERO_V);

    // Three back-to-back frames; pix[5] must still hold its original value
    iNumFrames = 4'd3; iStart = 1'b1;
    cyc();
    iStart = 1'b0;
    chk("multi_prime", 0, obs(), BUSY_V);
    cyc();
    check_run("multi", 3);

    // Zero frames
    iNumFrames = 4'd0; iStart = 1'b1;
    cyc();
    iStart = 1'b0;
    chk("zero_done", 0, obs(), DONE_V);
    cyc();
    chk("zero_idle", 0, obs(), ZERO_V);

    // Start and abort together in IDLE: abort wins
    iNumFrames = 4'd1; iStart = 1'b1; iAbort = 1'b1;
    cyc();
    iStart = 1'b0; iAbort = 1'b0;
    chk("start_abort", 0, obs(), ZERO_V);
    cyc();
    chk("start_abort2", 0, obs(), ZERO_V);

    // Abort at beat 500 of frame 1
    iNumFrames = 4'd3; iStart = 1'b1;
    cyc();
    iStart = 1'b0;
    cyc();
    for (int n = 0; n <= NPIX + 500; n++) begin
      chk("abort_beat", n, obs(), beat_v(n % NPIX, n / NPIX));
      if (n == NPIX + 500) iAbort = 1'b1;
      cyc();
    end
    iAbort = 1'b0;
    chk("abort_out", 0, obs(), ZERO_V);
    for (int n = 1; n < 6; n++) begin
      cyc();
      chk("abort_nodone", n, obs(), ZERO_V);
    end
    iNumFrames = 4'd1; iStart = 1'b1;
    cyc();
    iStart = 1'b0;
    chk("restart_prime", 0, obs(), BUSY_V);
    cyc();
    check_run("restart", 1);

    // Reset mid-stream, held 3 cycles
    iNumFrames = 4'd2; iStart = 1'b1;
    cyc();
    iStart = 1'b0;
    cyc();
    for (int j = 0; j <= 200; j++) begin
      chk("prerst_beat", j, obs(), beat_v(j, 0));
      if (j == 200) iRST = 1'b1;
      cyc();
    end
    chk("rst_out", 0, obs(), ZERO_V);
    cyc(); cyc();
    iRST = 1'b0;
    cyc();
    chk("rst_idle", 0, obs(), ZERO_V);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
